fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences the program counter against a request/grant/response instruction-memory port. It issues in-order fetches, tracks outstanding requests, and buffers returned instructions in a small FIFO. It discards stale responses after a branch/jal/jalr redirect, and holds issue while the shared memory port is busy with a load or store. It sits between the PC/fetch datapath and decode, and replaces the bare PC-advance enable with a proper handshake.

Parameters:
DEPTH, 2, number of instruction-buffer entries and maximum requests in flight (power of two, ≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
redirect_i  input  1  taken branch, jal or jalr resolved this cycle
redirect_addr_i  input  32  redirect target (ALU output); bits[1:0] ignored
mem_busy_i  input  1  load/store owns the memory port; no new fetch may issue
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address, word aligned
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid; responses return in request order
imem_rdata_i  input  32  instruction word
instr_valid_o  output  1  buffered instruction available to decode
instr_o  output  32  instruction at FIFO head
instr_pc_o  output  32  address of instr_o
instr_ready_i  input  1  decode consumes head when valid and ready

Behaviour:
- Reset (async, any cycle, including mid-transaction): pc_q=RESET_PC, state=BOOT, buffer empty, live_cnt=0, drop_cnt=0. imem_req_o=0, instr_valid_o=0, imem_addr_o=RESET_PC, instr_o=0, instr_pc_o=0.
- FSM states:
  - BOOT: one idle cycle after rst deasserts, then → FETCH.
  - FETCH: normal issue.
  - HOLD: entered when mem_busy_i=1 and no request is pending ungranted. Returns to FETCH the cycle after mem_busy_i=0.
  - redirect_i has priority in every state except BOOT and forces FETCH.
- Issue condition: imem_req_o = (state==FETCH) && !mem_busy_i && (live_cnt + drop_cnt + buf_count < DEPTH). imem_addr_o=pc_q.
- Request stability: once imem_req_o=1 without grant, req and addr stay stable. Exceptions:
  - redirect_i: addr changes to the target.
  - mem_busy_i rising: req may drop; memory tolerates withdrawal.
- Grant: req&&gnt → pc_q += 4 (wraps modulo 2^32, 32'hFFFF_FFFC → 0), live_cnt++.
- Response: imem_rvalid_i with drop_cnt>0 → discard, drop_cnt--. Otherwise push {pc, rdata} into the buffer and live_cnt--. The pc for each live response comes from a DEPTH-deep address queue written at grant.
- Latency: grant at cycle N, rvalid at cycle M ≥ N+1 → instr_valid_o at M+1 (registered buffer, no bypass).
- Pop: instr_valid_o && instr_ready_i. Push and pop in the same cycle are legal at full and at empty+1. The credit check guarantees push never overflows.
- Redirect (cycle R):
  - pc_q ← {redirect_addr_i[31:2],2'b00}.
  - Buffer and address queue flushed; instr_valid_o=0 at R+1.
  - drop_cnt ← drop_cnt + live_cnt, plus 1 if a grant occurs in R, minus 1 if a response arrives in R (that response is discarded).
  - live_cnt ← 0.
  - The first request to the target may issue at R+1.
- Redirect while mem_busy_i=1: pc_q updated, no issue until busy clears.
- Counters are clog2(DEPTH)+1 bits wide. Assertions: no underflow of live_cnt or drop_cnt; rvalid never arrives with live_cnt+drop_cnt==0.

Decomposition:
- rv32i_pkg holds: XLEN=32, RESET_PC default, the fetch_state_e enum {BOOT, FETCH, HOLD}, and the INSTR_NOP constant.
- Sub-module fetch_buffer: synchronous FIFO parameterised by DEPTH and width 64 ({pc, instr}), with push/pop/flush/count/full/empty.

Test Plan:
- Reset release, imem grants every cycle, 1-cycle response latency → addresses 0,4,8,12; instr_valid_o first high 3 cycles after BOOT exits; instr_pc_o sequence 0,4,8.
- instr_ready_i=0 for 10 cycles, DEPTH=2 → exactly 2 requests issued, then imem_req_o=0 until a pop; no data lost, order 0,4.
- Two requests in flight (0,4), redirect to 0x100 at R → both responses discarded, instr_valid_o=0 at R+1, next delivered instr_pc_o=0x100.
- Redirect in the same cycle as a grant of 8 and the response of 4 → drop_cnt ends correct; only 0x200 onward is delivered; no underflow assertion fires.
- mem_busy_i high 5 cycles while no request is pending → no imem_req_o during busy; fetch resumes at the next sequential pc the cycle after busy falls.
- rst asserted mid-stream with 2 outstanding → outputs reset immediately (async); stale post-reset rvalid is not delivered.

Source files
------------

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I fetch front end: datapath width, the
// default reset PC, the fetch controller state encoding and the canonical NOP.
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam int               XLEN             = 32;
    localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0]  INSTR_NOP        = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } fetch_state_e;

    // Instruction fetches are always word aligned; the low two bits of any
    // computed target are simply dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Small synchronous FIFO used twice by the fetch controller: as the
// instruction buffer ({pc, instr}) and as the in-flight address queue.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data at the tail (accepted when not full, or when
//               a pop happens in the same cycle)
//   push_data   entry to write
//   pop         remove the head entry (ignored when empty)
//   flush       discard all entries; wins over push and pop
//   head_data   entry at the head (undefined when empty)
//   count       number of stored entries, 0..DEPTH
//   full/empty  occupancy flags
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A push at full is legal only because the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; cnt/pointers define
    // which entries are meaningful, so resetting the data would only add cost.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Sequences the PC against a request/grant/response instruction-memory port.
// Issues in-order word fetches, keeps a credit count so that every response
// has a guaranteed buffer slot, discards stale responses after a redirect and
// stays off the port while a load/store owns it.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   redirect_i        taken branch / jal / jalr resolved this cycle
//   redirect_addr_i   redirect target; bits [1:0] ignored
//   mem_busy_i        load/store owns the memory port
//   imem_req_o        fetch request
//   imem_addr_o       fetch address (word aligned)
//   imem_gnt_i        request accepted this cycle
//   imem_rvalid_i     response valid (responses return in request order)
//   imem_rdata_i      instruction word
//   instr_valid_o     buffered instruction available to decode
//   instr_o           instruction at buffer head (0 when invalid)
//   instr_pc_o        address of instr_o (0 when invalid)
//   instr_ready_i     decode consumes the head when valid and ready
// -----------------------------------------------------------------------------
module fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    input  logic            mem_busy_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   live_cnt;   // granted requests whose data will be kept
    logic [CW-1:0]   drop_cnt;   // granted requests whose data will be discarded
    logic            req_pending_q;

    logic            redirect;
    logic            credit_ok;
    logic [CW+1:0]   in_flight;
    logic            grant;
    logic            rsp_any;
    logic            rsp_drop;
    logic            rsp_live;

    logic [XLEN-1:0] aq_head;
    logic [CW-1:0]   aq_count;
    logic            aq_full, aq_empty;
    logic            aq_push;

    logic [2*XLEN-1:0] ib_head;
    logic [CW-1:0]     ib_count;
    logic              ib_full, ib_empty;
    logic              ib_push, ib_pop;

    // Redirects arriving during the boot cycle have nothing to cancel.
    assign redirect = redirect_i && (state_q != BOOT);

    // Every request ever granted must have a slot waiting in the instruction
    // buffer, so dropped and buffered entries both consume credit.
    assign in_flight  = (CW+2)'(live_cnt) + (CW+2)'(drop_cnt) + (CW+2)'(ib_count);
    assign credit_ok  = (in_flight < (CW+2)'(DEPTH));
    assign imem_req_o = (state_q == FETCH) && !mem_busy_i && credit_ok;
    assign imem_addr_o = pc_q;
    assign grant      = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding is ignored (and flagged below).
    assign rsp_any  = imem_rvalid_i && ((live_cnt != '0) || (drop_cnt != '0));
    assign rsp_drop = rsp_any && (drop_cnt != '0);
    assign rsp_live = rsp_any && (drop_cnt == '0);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (redirect) begin
                    state_d = FETCH;
                end else if (mem_busy_i && !req_pending_q) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !mem_busy_i) begin
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // -------------------------------------------------------- PC / counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            live_cnt      <= '0;
            drop_cnt      <= '0;
            req_pending_q <= 1'b0;
        end else begin
            // A request left hanging without grant keeps FETCH from sliding
            // into HOLD until it has been withdrawn.
            req_pending_q <= imem_req_o && !imem_gnt_i && !redirect;
            if (redirect) begin
                pc_q     <= word_align(redirect_addr_i);
                live_cnt <= '0;
                // Everything still outstanding, including a grant taken this
                // cycle, becomes stale; a response arriving now is already gone.
                drop_cnt <= drop_cnt + live_cnt + CW'(grant) - CW'(rsp_any);
            end else begin
                if (grant) pc_q <= pc_q + 32'd4;
                live_cnt <= live_cnt + CW'(grant) - CW'(rsp_live);
                drop_cnt <= drop_cnt - CW'(rsp_drop);
            end
        end
    end

    // ------------------------------------------------ address queue (PCs)
    assign aq_push = grant && !redirect;

    fetch_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (aq_push),
        .push_data (pc_q),
        .pop       (rsp_live),
        .flush     (redirect),
        .head_data (aq_head),
        .count     (aq_count),
        .full      (aq_full),
        .empty     (aq_empty)
    );

    // -------------------------------------------------- instruction buffer
    assign ib_push = rsp_live && !redirect;
    assign ib_pop  = instr_valid_o && instr_ready_i;

    fetch_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_instr_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (ib_push),
        .push_data ({aq_head, imem_rdata_i}),
        .pop       (ib_pop),
        .flush     (redirect),
        .head_data (ib_head),
        .count     (ib_count),
        .full      (ib_full),
        .empty     (ib_empty)
    );

    assign instr_valid_o = !ib_empty;
    assign instr_o       = instr_valid_o ? ib_head[XLEN-1:0]      : '0;
    assign instr_pc_o    = instr_valid_o ? ib_head[2*XLEN-1:XLEN] : '0;

    // ----------------------------------------------------------- invariants
    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> ((live_cnt != '0) || (drop_cnt != '0)));

    a_aq_tracks_live: assert property (@(posedge clk) disable iff (rst)
        (aq_count == live_cnt) && (aq_empty == (live_cnt == '0)));

    a_aq_no_overflow: assert property (@(posedge clk) disable iff (rst)
        aq_push |-> (!aq_full || rsp_live));

    a_ib_no_overflow: assert property (@(posedge clk) disable iff (rst)
        ib_push |-> (!ib_full || ib_pop));

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl (DEPTH=2, RESET_PC=0). The bench plays the
// instruction memory by hand, cycle by cycle. Inputs change 1 time unit after
// the rising edge; outputs are compared one unit later.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        mem_busy_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl #(
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .mem_busy_i      (mem_busy_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the bench memory returns for a given address.
    function automatic logic [31:0] mk(input logic [31:0] addr);
        return 32'hC0DE_0000 | {16'h0000, addr[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect_i      = 1'b0;
        redirect_addr_i = 32'h0;
        mem_busy_i      = 1'b0;
        imem_gnt_i      = 1'b0;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = 32'h0;
        instr_ready_i   = 1'b0;
    endtask

    // Reset, release into the BOOT cycle, and return at the first FETCH cycle.
    task automatic restart();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        // ---------------- reset state
        check("rst_req",   imem_req_o,    1'b0);
        check("rst_addr",  imem_addr_o,   32'h0);
        check("rst_valid", instr_valid_o, 1'b0);
        check("rst_instr", instr_o,       32'h0);
        check("rst_pc",    instr_pc_o,    32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("boot_req", imem_req_o, 1'b0);
        tick();

        // ---------------- T1: grants every cycle, 1-cycle response latency
        imem_gnt_i = 1'b1;
        #1;
        check("t1_req0",  imem_req_o,  1'b1);
        check("t1_addr0", imem_addr_o, 32'h0);
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h0);
        #1;
        check("t1_addr4",   imem_addr_o,   32'h4);
        check("t1_valid_n", instr_valid_o, 1'b0);
        tick();
        imem_rdata_i = mk(32'h4); instr_ready_i = 1'b1;
        #1;
        check("t1_valid0", instr_valid_o, 1'b1);
        check("t1_pc0",    instr_pc_o,    32'h0);
        check("t1_instr0", instr_o,       mk(32'h0));
        check("t1_credit", imem_req_o,    1'b0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("t1_pc4",   instr_pc_o,  32'h4);
        check("t1_addr8", imem_addr_o, 32'h8);
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h8);
        #1;
        check("t1_addr12", imem_addr_o, 32'hC);
        tick();
        imem_rdata_i = mk(32'hC);
        #1;
        check("t1_pc8",    instr_pc_o,  32'h8);
        check("t1_instr8", instr_o,     mk(32'h8));
        tick();
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0;
        #1;
        check("t1_pc12",   instr_pc_o,  32'hC);
        check("t1_req16",  imem_req_o,  1'b1);
        tick();

        // ---------------- T2: decode stalled for 10 cycles
        instr_ready_i = 1'b0; imem_gnt_i = 1'b1;
        #1;
        check("t2_hold_addr16", imem_addr_o, 32'h10);
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h10);
        #1;
        check("t2_addr20", imem_addr_o, 32'h14);
        check("t2_req20",  imem_req_o,  1'b1);
        tick();
        imem_rdata_i = mk(32'h14);
        #1;
        check("t2_full_req", imem_req_o, 1'b0);
        tick();
        imem_rvalid_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("t2_stall_req", imem_req_o, 1'b0);
            check("t2_stall_pc",  instr_pc_o, 32'h10);
            tick();
        end
        instr_ready_i = 1'b1;
        #1;
        check("t2_pop_req", imem_req_o, 1'b0);
        check("t2_pop_pc",  instr_pc_o, 32'h10);
        tick();
        instr_ready_i = 1'b0; imem_gnt_i = 1'b0;
        #1;
        check("t2_pc20",    instr_pc_o,  32'h14);
        check("t2_instr20", instr_o,     mk(32'h14));
        check("t2_resume",  imem_req_o,  1'b1);
        check("t2_addr24",  imem_addr_o, 32'h18);

        // ---------------- T3: redirect with two requests in flight
        restart();
        imem_gnt_i = 1'b1;
        #1;
        check("t3_addr0", imem_addr_o, 32'h0);
        tick();
        #1;
        check("t3_addr4", imem_addr_o, 32'h4);
        tick();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_addr_i = 32'h0000_0103;
        #1;
        check("t3_r_req", imem_req_o, 1'b0);
        tick();
        redirect_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h0);
        #1;
        check("t3_r1_valid", instr_valid_o, 1'b0);
        check("t3_r1_req",   imem_req_o,    1'b0);
        check("t3_r1_addr",  imem_addr_o,   32'h100);
        tick();
        imem_rdata_i = mk(32'h4); imem_gnt_i = 1'b1;
        #1;
        check("t3_drop_valid", instr_valid_o, 1'b0);
        check("t3_tgt_req",    imem_req_o,    1'b1);
        check("t3_tgt_addr",   imem_addr_o,   32'h100);
        tick();
        imem_gnt_i = 1'b0; imem_rdata_i = mk(32'h100);
        #1;
        check("t3_drop2_valid", instr_valid_o, 1'b0);
        tick();
        imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
        #1;
        check("t3_valid", instr_valid_o, 1'b1);
        check("t3_pc",    instr_pc_o,    32'h100);
        check("t3_instr", instr_o,       mk(32'h100));

        // ---------------- T4: redirect coincides with grant(8) and response(4)
        restart();
        imem_gnt_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h0);
        #1;
        check("t4_addr4", imem_addr_o, 32'h4);
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
        #1;
        check("t4_pc0", instr_pc_o, 32'h0);
        tick();
        instr_ready_i = 1'b0; imem_gnt_i = 1'b1;
        imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h4);
        redirect_i = 1'b1; redirect_addr_i = 32'h0000_0200;
        #1;
        check("t4_r_req",  imem_req_o,  1'b1);
        check("t4_r_addr", imem_addr_o, 32'h8);
        tick();
        redirect_i = 1'b0; imem_rvalid_i = 1'b0;
        #1;
        check("t4_r1_valid", instr_valid_o, 1'b0);
        check("t4_tgt_addr", imem_addr_o,   32'h200);
        check("t4_tgt_req",  imem_req_o,    1'b1);
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h8);
        #1;
        check("t4_credit", imem_req_o,    1'b0);
        check("t4_drop8",  instr_valid_o, 1'b0);
        tick();
        imem_rdata_i = mk(32'h200);
        #1;
        check("t4_pre_valid", instr_valid_o, 1'b0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("t4_valid", instr_valid_o, 1'b1);
        check("t4_pc",    instr_pc_o,    32'h200);
        check("t4_instr", instr_o,       mk(32'h200));

        // ---------------- T5: mem_busy high for 5 cycles, nothing pending
        restart();
        imem_gnt_i = 1'b1;
        #1;
        check("t5_addr0", imem_addr_o, 32'h0);
        tick();
        mem_busy_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h0);
        #1;
        check("t5_busy_req", imem_req_o, 1'b0);
        tick();
        imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
        #1;
        check("t5_busy_req", imem_req_o, 1'b0);
        check("t5_busy_pc0", instr_pc_o, 32'h0);
        tick();
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_busy_req", imem_req_o, 1'b0);
            tick();
        end
        mem_busy_i = 1'b0;
        #1;
        check("t5_fall_req", imem_req_o, 1'b0);
        tick();
        #1;
        check("t5_resume_req",  imem_req_o,  1'b1);
        check("t5_resume_addr", imem_addr_o, 32'h4);
        tick();

        // ---------------- T6: asynchronous reset mid-stream
        restart();
        imem_gnt_i = 1'b1;
        tick();
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("t6_pre_valid", instr_valid_o, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_async_valid", instr_valid_o, 1'b0);
        check("t6_async_instr", instr_o,       32'h0);
        check("t6_async_pc",    instr_pc_o,    32'h0);
        check("t6_async_req",   imem_req_o,    1'b0);
        check("t6_async_addr",  imem_addr_o,   32'h0);
        imem_rvalid_i = 1'b1; imem_rdata_i = mk(32'h4);
        tick();
        imem_rvalid_i = 1'b0;
        rst = 1'b0;
        #1;
        check("t6_boot_req",   imem_req_o,    1'b0);
        check("t6_boot_valid", instr_valid_o, 1'b0);
        tick();
        #1;
        check("t6_fetch_req",   imem_req_o,    1'b1);
        check("t6_fetch_addr",  imem_addr_o,   32'h0);
        check("t6_stale_valid", instr_valid_o, 1'b0);
        tick();
        #1;
        check("t6_stale_valid2", instr_valid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
